// File: rtl/if_fetch_queue.sv
// Fetch-to-decode instruction queue: holds {pc, pc_next, ir} per entry,
// absorbs decode stalls and empties itself on a taken-branch flush.
module if_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [XLEN-1:0]          enq_pc_next,
    input  logic [XLEN-1:0]          enq_ir,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_pc_next,
    output logic [XLEN-1:0]          deq_ir,
    input  logic                     deq_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0] pc_mem      [DEPTH];
    logic [XLEN-1:0] pc_next_mem [DEPTH];
    logic [XLEN-1:0] ir_mem      [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          enq_fire;
    logic          deq_fire;

    // Ready depends only on registered occupancy: no write-through when full.
    assign enq_ready = (count != FULL);
    assign deq_valid = (count != '0);
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;

    assign deq_pc      = pc_mem[rd_ptr];
    assign deq_pc_next = pc_next_mem[rd_ptr];
    assign deq_ir      = ir_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + AW'(1);
            if (deq_fire) rd_ptr <= rd_ptr + AW'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            pc_mem[wr_ptr]      <= enq_pc;
            pc_next_mem[wr_ptr] <= enq_pc_next;
            ir_mem[wr_ptr]      <= enq_ir;
        end
    end

endmodule
